// File: rtl/multi_bit_fifo_n.sv
// Parametrised synchronous FIFO with drop/overwrite-on-full mode, occupancy count,
// watermark flags and one-cycle overflow/underflow pulses.
module multi_bit_fifo_n #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int AF_LEVEL   = DEPTH - 1,
    parameter int AE_LEVEL   = 1
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [DATA_WIDTH-1:0]    din,
    input  logic                     wr,
    input  logic                     rd,
    input  logic                     ovw_mode,
    output logic [DATA_WIDTH-1:0]    dout,
    output logic                     dout_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;

    logic          is_full;
    logic          is_empty;
    logic          rd_acc;
    logic          wr_acc;
    logic          ovw_evict;
    logic          rd_adv;
    logic          ovf_n;
    logic          unf_n;
    logic [CW-1:0] count_n;

    always_comb begin
        is_full   = (count == DEPTH_C);
        is_empty  = (count == '0);
        rd_acc    = rd && !is_empty;
        wr_acc    = wr && (!is_full || rd_acc || ovw_mode);
        // Overwrite on full: the write lands on the oldest slot, so the read pointer
        // moves past it while count stays at DEPTH.
        ovw_evict = wr_acc && !rd_acc && is_full;
        rd_adv    = rd_acc || ovw_evict;
        ovf_n     = wr && !rd_acc && is_full;
        unf_n     = rd && is_empty;
        count_n   = count;
        if (wr_acc && !rd_acc && !is_full) begin
            count_n = count + CW'(1);
        end else if (rd_acc && !wr_acc) begin
            count_n = count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            dout         <= '0;
            dout_valid   <= 1'b0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= (AF_LEVEL == 0);
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_adv) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (rd_acc) begin
                dout <= mem[rd_ptr];
            end
            dout_valid   <= rd_acc;
            count        <= count_n;
            full         <= (count_n == DEPTH_C);
            empty        <= (count_n == '0);
            almost_full  <= (count_n >= AF_C);
            almost_empty <= (count_n <= AE_C);
            overflow     <= ovf_n;
            underflow    <= unf_n;
        end
    end

endmodule
